// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder for a word-wide ram_top port.
// Sub-word stores are read-modify-write because ram_top has no byte enables.
module dmem_responder #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wen,
    input  logic [31:0]       ram_rdata
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lo_q, lo_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_wen_q, ram_wen_d;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              req_bad;

    always_comb begin
        rd_byte  = ram_rdata[{lo_q, 3'b000} +: 8];
        rd_half  = ram_rdata[{lo_q[1], 4'b0000} +: 16];
        load_val = (size_q == 2'd0) ? {{24{~uns_q & rd_byte[7]}}, rd_byte} :
                   (size_q == 2'd1) ? {{16{~uns_q & rd_half[15]}}, rd_half} : ram_rdata;
        merged   = ram_rdata;
        if (size_q == 2'd0)
            merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lo_q[1], 4'b0000} +: 16] = wdata_q;
        req_bad  = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && |req_addr[1:0]);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lo_d        = lo_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d        = req_we;
                size_d      = req_size;
                uns_d       = req_unsigned;
                lo_d        = req_addr[1:0];
                wdata_d     = req_wdata[15:0];
                rsp_rdata_d = '0;
                rsp_err_d   = req_bad;
                if (req_bad) begin
                    state_d = RESP;
                end else begin
                    ram_addr_d = req_addr[ADDR_W+1:2];
                    if (req_we && req_size == 2'd2) begin
                        ram_wdata_d = req_wdata;
                        state_d     = WRITE;
                    end else begin
                        cnt_d   = CW'(RD_LAT);
                        state_d = RD_WAIT;
                    end
                end
            end
            // Read data is sampled on the RD_LAT-th edge after ram_addr was launched.
            RD_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    if (we_q) begin
                        ram_wdata_d = merged;
                        state_d     = WRITE;
                    end else begin
                        rsp_rdata_d = load_val;
                        state_d     = RESP;
                    end
                end
            end
            WRITE: state_d = RESP;
            RESP: state_d = rsp_ready ? IDLE : RESP;
        endcase
        ram_wen_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            lo_q        <= 2'd0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lo_q        <= lo_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wen   = ram_wen_q;
endmodule
